// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: port indices, rr_last encoding and write-record type shared by the write arbiter.
package rf_write_arbiter_pkg;

    localparam int RF_ARB_P_WB   = 0;
    localparam int RF_ARB_P_FPU  = 1;
    localparam int RF_ARB_P_MEM  = 2;
    localparam int RF_ARB_NPORTS = 3;

    localparam logic [1:0] RF_ARB_RR_FPU = 2'd1;
    localparam logic [1:0] RF_ARB_RR_MEM = 2'd2;
    localparam logic [1:0] RF_ARB_RR_RST = RF_ARB_RR_MEM;

    typedef struct packed {
        logic        floating;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_starve_ctr.sv
// rf_arb_starve_ctr: saturating starvation counter; at_limit is high while the count equals LIMIT.
module rf_arb_starve_ctr #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIM = LIMIT[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign at_limit = cnt_q == LIM;

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: grants one of WB/FPU/refill per cycle onto the shared register-file write port via a registered stage.
// Define RF_ARB_STARVE_EN to build the starvation guard that lets ports 1/2 preempt port 0.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_valid,
    input  logic [4:0]  p0_addr,
    input  logic        p0_floating,
    input  logic [31:0] p0_data,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [4:0]  p1_addr,
    input  logic        p1_floating,
    input  logic [31:0] p1_data,
    output logic        p1_ready,
    input  logic        p2_valid,
    input  logic [4:0]  p2_addr,
    input  logic        p2_floating,
    input  logic [31:0] p2_data,
    output logic        p2_ready,
    output logic        wen,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        floatingWB,
    output logic        stall_pipe
);

    logic [RF_ARB_NPORTS-1:0] gnt;
    logic                     pick1, pick2, pair, preempt, xfer;
    logic [1:0]               rr_last_q, rr_last_d;
    logic                     wen_q, wen_d;
    rf_wr_t                   wr_q, wr_d, sel;

    always_comb begin
        pick1 = p1_valid & (~p2_valid | (rr_last_q == RF_ARB_RR_MEM));
        pick2 = p2_valid & ~pick1;
        pair  = p1_valid | p2_valid;
        gnt[RF_ARB_P_WB]  = ~reset & p0_valid & ~(preempt & pair);
        gnt[RF_ARB_P_FPU] = ~reset & pick1 & (~p0_valid | preempt);
        gnt[RF_ARB_P_MEM] = ~reset & pick2 & (~p0_valid | preempt);
    end

    always_comb begin
        sel = gnt[RF_ARB_P_FPU] ? rf_wr_t'{p1_floating, p1_addr, p1_data} :
              gnt[RF_ARB_P_MEM] ? rf_wr_t'{p2_floating, p2_addr, p2_data} :
                                  rf_wr_t'{p0_floating, p0_addr, p0_data};
        xfer = |gnt;
        // integer x0 is hardwired zero: accept the write but never enable it
        wen_d = xfer & (sel.floating | (sel.addr != 5'd0));
        wr_d  = xfer ? sel : wr_q;
        rr_last_d = gnt[RF_ARB_P_FPU] ? RF_ARB_RR_FPU :
                    gnt[RF_ARB_P_MEM] ? RF_ARB_RR_MEM : rr_last_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wen_q     <= 1'b0;
            wr_q      <= '0;
            rr_last_q <= RF_ARB_RR_RST;
        end else begin
            wen_q     <= wen_d;
            wr_q      <= wr_d;
            rr_last_q <= rr_last_d;
        end
    end

`ifdef RF_ARB_STARVE_EN
    rf_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT),
        .CNT_W(CNT_W)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .inc     (pair & ~(gnt[RF_ARB_P_FPU] | gnt[RF_ARB_P_MEM])),
        .clr     (~pair | gnt[RF_ARB_P_FPU] | gnt[RF_ARB_P_MEM]),
        .at_limit(preempt)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (STARVE_LIMIT + CNT_W) != 0;
    assign preempt    = 1'b0;
`endif

    assign p0_ready   = gnt[RF_ARB_P_WB];
    assign p1_ready   = gnt[RF_ARB_P_FPU];
    assign p2_ready   = gnt[RF_ARB_P_MEM];
    assign stall_pipe = ~reset & p0_valid & ~gnt[RF_ARB_P_WB];
    assign wen        = wen_q;
    assign wa         = wr_q.addr;
    assign wd         = wr_q.data;
    assign floatingWB = wr_q.floating;

endmodule
